store_buffer_fifo: RTL

STORE_BUFFER_FIFO -- requirements
Module: store_buffer_fifo

---
 rtl/store_buffer_fifo_if.sv | 63 ++++++
 rtl/store_buffer_fifo.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/store_buffer_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer_fifo_if
// Purpose  : Bundles the store, load-lookup, drain and status channels of the
//            store buffer.
// Modports : master - store/load requester and drain consumer
//                     (drives st_*, ld_valid/ld_addr, dr_ready)
//            slave  - the store buffer itself
// Signals  : st_valid/st_ready/st_addr/st_data/st_be   store request
//            ld_valid/ld_addr -> ld_hit/ld_be/ld_data  forwarding lookup
//            dr_valid/dr_ready/dr_addr/dr_data/dr_be   drain to cache
//            count/full/empty                          occupancy status
// Revision : 1.0 - initial release
// ============================================================================
interface store_buffer_fifo_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [BE_W-1:0]   st_be;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [BE_W-1:0]   ld_be;
  logic [DATA_W-1:0] ld_data;

  logic              dr_valid;
  logic              dr_ready;
  logic [ADDR_W-1:0] dr_addr;
  logic [DATA_W-1:0] dr_data;
  logic [BE_W-1:0]   dr_be;

  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  modport master (
    output st_valid, st_addr, st_data, st_be,
    output ld_valid, ld_addr,
    output dr_ready,
    input  st_ready, ld_hit, ld_be, ld_data,
    input  dr_valid, dr_addr, dr_data, dr_be,
    input  count, full, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_be,
    input  ld_valid, ld_addr,
    input  dr_ready,
    output st_ready, ld_hit, ld_be, ld_data,
    output dr_valid, dr_addr, dr_data, dr_be,
    output count, full, empty
  );
endinterface
`default_nettype wire

// File: rtl/store_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer_fifo
// Purpose  : In-order store buffer. Stores are queued in FIFO order, drained
//            oldest-first to the cache, and loads are forwarded byte-by-byte
//            from the youngest matching buffered store.
// Ports    : clk  - single clock, rising edge
//            rst  - asynchronous active-low reset
//            bus  - store_buffer_fifo_if.slave (store / load / drain / status)
// Options  : STORE_BUFFER_COALESCE_EN - when defined, a store merges into the
//            youngest valid matching non-head entry instead of allocating.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  store_buffer_fifo_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entries hold the word-aligned address, so address compares and the drain
  // address both ignore the byte offset.
  localparam logic [ADDR_W-1:0] c_word_mask = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);
  localparam logic [CNT_W-1:0]  c_depth     = CNT_W'(DEPTH);

  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [BE_W-1:0]   r_be   [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_st_ready;
  logic              w_st_fire;
  logic              w_alloc;
  logic              w_merge;
  logic              w_drain;
  logic              w_co_hit;
  logic [PTR_W-1:0]  w_co_idx;
  logic [ADDR_W-1:0] w_st_waddr;
  logic [ADDR_W-1:0] w_ld_waddr;
  logic [BE_W-1:0]   w_fwd_be;
  logic [DATA_W-1:0] w_fwd_data;

  assign w_full     = (r_count == c_depth);
  assign w_empty    = (r_count == '0);
  assign w_st_waddr = bus.st_addr & c_word_mask;
  assign w_ld_waddr = bus.ld_addr & c_word_mask;

`ifdef STORE_BUFFER_COALESCE_EN
  // Youngest valid matching entry, excluding the head so the entry being
  // presented on the drain channel never changes underneath the cache.
  always_comb begin : p_coalesce
    logic [PTR_W-1:0] idx;
    idx      = '0;
    w_co_hit = 1'b0;
    w_co_idx = '0;
    for (int k = 1; k < DEPTH; k++) begin
      idx = r_head + PTR_W'(k);
      if (r_valid[idx] && (r_addr[idx] == w_st_waddr)) begin
        w_co_hit = 1'b1;
        w_co_idx = idx;
      end
    end
  end
  assign w_st_ready = !w_full || w_co_hit;
`else
  assign w_co_hit   = 1'b0;
  assign w_co_idx   = '0;
  assign w_st_ready = !w_full;
`endif

  // Zero byte-enable stores are accepted but change nothing.
  assign w_st_fire = bus.st_valid && w_st_ready;
  assign w_alloc   = w_st_fire && (bus.st_be != '0) && !w_co_hit;
  assign w_merge   = w_st_fire && (bus.st_be != '0) && w_co_hit;
  assign w_drain   = !w_empty && bus.dr_ready;

  // Control state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      case ({w_alloc, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload arrays; qualified by r_valid so they need no reset.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_addr[r_tail] <= w_st_waddr;
      r_data[r_tail] <= bus.st_data;
      r_be[r_tail]   <= bus.st_be;
    end else if (w_merge) begin
      r_be[w_co_idx] <= r_be[w_co_idx] | bus.st_be;
      for (int b = 0; b < BE_W; b++) begin
        if (bus.st_be[b]) begin
          r_data[w_co_idx][b*8 +: 8] <= bus.st_data[b*8 +: 8];
        end
      end
    end
  end

  // Forwarding: walk oldest to youngest so younger entries overwrite older
  // bytes. The head is included even in the cycle it drains.
  always_comb begin : p_forward
    logic [PTR_W-1:0] idx;
    idx        = '0;
    w_fwd_be   = '0;
    w_fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_head + PTR_W'(k);
      if (r_valid[idx] && (r_addr[idx] == w_ld_waddr)) begin
        for (int b = 0; b < BE_W; b++) begin
          if (r_be[idx][b]) begin
            w_fwd_be[b]          = 1'b1;
            w_fwd_data[b*8 +: 8] = r_data[idx][b*8 +: 8];
          end
        end
      end
    end
  end

  assign bus.st_ready = w_st_ready;
  assign bus.ld_be    = bus.ld_valid ? w_fwd_be   : '0;
  assign bus.ld_data  = bus.ld_valid ? w_fwd_data : '0;
  assign bus.ld_hit   = bus.ld_valid && (w_fwd_be != '0);
  assign bus.dr_valid = !w_empty;
  assign bus.dr_addr  = r_addr[r_head];
  assign bus.dr_data  = r_data[r_head];
  assign bus.dr_be    = r_be[r_head];
  assign bus.count    = r_count;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
endmodule
`default_nettype wire
